// File: rtl/bip_host_ctrl.sv
// rtl/bip_host_ctrl.sv - host-side sequencer for one BIP start/readback transaction over a UART FIFO pair
//
// Flushes stale receive bytes, sends the start command, then collects two
// response bytes (cycle count, accumulator low byte). Each awaited byte has
// its own idle-cycle timeout.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   go                 start request, only looked at in IDLE
//   busy, done         transaction in progress / one-cycle end pulse
//   timeout_err        a response byte never arrived; cleared by the next go
//   clk_count          first response byte
//   acc_byte           second response byte
//   rx_empty, r_data   receive FIFO status and head byte
//   rd_uart            receive FIFO pop strobe
//   tx_full            transmit FIFO full flag
//   w_data, wr_uart    transmit FIFO byte and push strobe
module bip_host_ctrl #(
  parameter logic [7:0]         CMD_START = 8'd8,
  parameter int                 TO_BITS   = 20,
  parameter logic [TO_BITS-1:0] TO_LIMIT  = 20'hFFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic [7:0] clk_count,
  output logic [7:0] acc_byte,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLUSH    = 3'd1,
    SEND     = 3'd2,
    WAIT_CNT = 3'd3,
    WAIT_ACC = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [TO_BITS-1:0] to_cnt;
  logic               load_cnt;
  logic               load_acc;
  logic               to_hit;
  logic               entering_wait;
  logic               in_wait;

  always_comb begin
    state_next = state;
    rd_uart    = 1'b0;
    wr_uart    = 1'b0;
    load_cnt   = 1'b0;
    load_acc   = 1'b0;
    to_hit     = 1'b0;
    case (state)
      IDLE: begin
        if (go) state_next = FLUSH;
      end
      FLUSH: begin
        // Drain anything left over from an earlier run, one byte per cycle.
        if (!rx_empty) rd_uart = 1'b1;
        else           state_next = SEND;
      end
      SEND: begin
        if (!tx_full) begin
          wr_uart    = 1'b1;
          state_next = WAIT_CNT;
        end
      end
      WAIT_CNT: begin
        // An arriving byte wins over a timeout that expires in the same cycle.
        if (!rx_empty) begin
          rd_uart    = 1'b1;
          load_cnt   = 1'b1;
          state_next = WAIT_ACC;
        end else if (to_cnt == TO_LIMIT) begin
          to_hit     = 1'b1;
          state_next = DONE;
        end
      end
      WAIT_ACC: begin
        if (!rx_empty) begin
          rd_uart    = 1'b1;
          load_acc   = 1'b1;
          state_next = DONE;
        end else if (to_cnt == TO_LIMIT) begin
          to_hit     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Strobes must stay quiet during reset so FIFO contents survive an abort.
    if (reset) begin
      rd_uart = 1'b0;
      wr_uart = 1'b0;
    end
  end

  assign in_wait       = (state == WAIT_CNT) || (state == WAIT_ACC);
  assign entering_wait = (state_next != state) &&
                         ((state_next == WAIT_CNT) || (state_next == WAIT_ACC));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      clk_count   <= 8'd0;
      acc_byte    <= 8'd0;
      w_data      <= 8'd0;
      to_cnt      <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE) && (state_next != DONE);
      done  <= (state_next == DONE);

      if ((state == IDLE) && go) begin
        timeout_err <= 1'b0;
        w_data      <= CMD_START;
      end
      if (to_hit)   timeout_err <= 1'b1;
      if (load_cnt) clk_count   <= r_data;
      if (load_acc) acc_byte    <= r_data;

      // Each awaited byte gets a fresh timeout window.
      if (entering_wait)
        to_cnt <= '0;
      else if (in_wait && rx_empty)
        to_cnt <= to_cnt + TO_BITS'(1);
    end
  end

endmodule

// File: tb/tb_bip_host_ctrl.sv
// tb/tb_bip_host_ctrl.sv - directed self-checking bench for bip_host_ctrl
module tb_bip_host_ctrl;

  logic       clk;
  logic       reset;
  logic       go;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic [7:0] clk_count;
  logic [7:0] acc_byte;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic [7:0] w_data;
  logic       wr_uart;

  bip_host_ctrl #(
    .CMD_START (8'd8),
    .TO_BITS   (20),
    .TO_LIMIT  (20'd16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .clk_count   (clk_count),
    .acc_byte    (acc_byte),
    .rx_empty    (rx_empty),
    .r_data      (r_data),
    .rd_uart     (rd_uart),
    .tx_full     (tx_full),
    .w_data      (w_data),
    .wr_uart     (wr_uart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receive FIFO model: bench pushes, DUT pops on rd_uart.
  logic [7:0] rx_mem [0:15];
  int         rx_head = 0;
  int         rx_tail = 0;
  assign rx_empty = (rx_head == rx_tail);
  assign r_data   = rx_mem[rx_head[3:0]];

  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_uart && !rx_empty) rx_head <= rx_head + 1;
  end

  // Monitor on the falling edge, away from the active edge.
  int         wr_cnt   = 0;
  int         rd_cnt   = 0;
  int         done_cnt = 0;
  int         wr_cyc   = 0;
  int         done_cyc = 0;
  int         bad_strb = 0;
  logic [7:0] last_w   = 8'd0;
  always @(negedge clk) begin
    if (wr_uart) begin
      wr_cnt = wr_cnt + 1;
      wr_cyc = cyc;
      last_w = w_data;
    end
    if (rd_uart) rd_cnt = rd_cnt + 1;
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if ((rd_uart && wr_uart) || (reset && (rd_uart || wr_uart)))
      bad_strb = bad_strb + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_mem[rx_tail[3:0]] = b;
    rx_tail = rx_tail + 1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_wr(input int budget, input string tag);
    int start;
    int n;
    start = wr_cnt;
    n = 0;
    while (wr_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check(32'(wr_cnt - start), 32'd1, {tag, "_wr_seen"});
  endtask

  task automatic wait_done(input int budget, input string tag);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check(32'(done_cnt - start), 32'd1, {tag, "_done_seen"});
  endtask

  int rd0;
  int wr0;
  int dn0;
  int fall_cyc;
  int s;

  initial begin
    reset   = 1'b1;
    go      = 1'b0;
    tx_full = 1'b0;
    repeat (3) tick();

    // Reset state
    check(32'(busy),        32'd0, "rst_busy");
    check(32'(done),        32'd0, "rst_done");
    check(32'(timeout_err), 32'd0, "rst_to");
    check(32'(clk_count),   32'd0, "rst_clk_count");
    check(32'(acc_byte),    32'd0, "rst_acc");
    check(32'(w_data),      32'd0, "rst_w_data");
    check(32'(rd_uart),     32'd0, "rst_rd");
    check(32'(wr_uart),     32'd0, "rst_wr");
    reset = 1'b0;
    tick();

    // Basic transaction: response 0x2A, 0x07
    pulse_go();
    check(32'(busy), 32'd1, "t1_busy_after_go");
    wait_wr(20, "t1");
    check(32'(last_w), 32'h08, "t1_cmd_byte");
    push(8'h2A);
    push(8'h07);
    wait_done(50, "t1");
    check(32'(clk_count),   32'h2A, "t1_clk_count");
    check(32'(acc_byte),    32'h07, "t1_acc");
    check(32'(timeout_err), 32'd0,  "t1_to");
    repeat (3) tick();
    check(32'(done_cnt), 32'd1, "t1_single_done");
    check(32'(wr_cnt),   32'd1, "t1_single_wr");
    check(32'(busy),     32'd0, "t1_idle_busy");

    // Two stale bytes are flushed before the command goes out
    push(8'hAA);
    push(8'hBB);
    tick();
    rd0 = rd_cnt;
    pulse_go();
    wait_wr(20, "t2");
    check(32'(rd_cnt - rd0), 32'd2, "t2_flush_pops");
    push(8'h10);
    push(8'h03);
    wait_done(50, "t2");
    check(32'(clk_count),    32'h10, "t2_clk_count");
    check(32'(acc_byte),     32'h03, "t2_acc");
    check(32'(rd_cnt - rd0), 32'd4,  "t2_total_pops");
    check(32'(timeout_err),  32'd0,  "t2_to");

    // Transmit FIFO full for 50 cycles: no push, no timeout
    tx_full = 1'b1;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    pulse_go();
    repeat (50) tick();
    check(32'(wr_cnt - wr0),   32'd0, "t3_no_wr_while_full");
    check(32'(done_cnt - dn0), 32'd0, "t3_no_done_while_full");
    check(32'(busy),           32'd1, "t3_busy_while_full");
    tx_full  = 1'b0;
    fall_cyc = cyc;
    wait_wr(5, "t3");
    check(32'(wr_cyc), 32'(fall_cyc), "t3_wr_cycle");
    push(8'h11);
    push(8'h22);
    wait_done(50, "t3");
    check(32'(clk_count),   32'h11, "t3_clk_count");
    check(32'(acc_byte),    32'h22, "t3_acc");
    check(32'(timeout_err), 32'd0,  "t3_to");

    // No response at all: timeout 17 cycles after WAIT_CNT entry
    pulse_go();
    wait_wr(20, "t4");
    s = wr_cyc;
    wait_done(40, "t4");
    check(32'(done_cyc - (s + 1)), 32'd17, "t4_timeout_latency");
    check(32'(timeout_err),        32'd1,  "t4_to_set");
    check(32'(clk_count),          32'h11, "t4_clk_count_kept");
    check(32'(acc_byte),           32'h22, "t4_acc_kept");

    // Byte arrives in the very cycle the counter reaches the limit
    pulse_go();
    check(32'(timeout_err), 32'd0, "t5_to_cleared_by_go");
    wait_wr(20, "t5");
    s = wr_cyc;
    while (cyc < s + 17) tick();
    push(8'h33);
    push(8'h44);
    wait_done(20, "t5");
    check(32'(clk_count),   32'h33,        "t5_clk_count");
    check(32'(acc_byte),    32'h44,        "t5_acc");
    check(32'(timeout_err), 32'd0,         "t5_no_timeout");
    check(32'(done_cyc),    32'(s + 19),   "t5_done_cycle");

    // First byte arrives, second never does
    pulse_go();
    wait_wr(20, "t6");
    s = wr_cyc;
    push(8'h05);
    wait_done(60, "t6");
    check(32'(clk_count),   32'h05,      "t6_clk_count");
    check(32'(acc_byte),    32'h44,      "t6_acc_kept");
    check(32'(timeout_err), 32'd1,       "t6_to_set");
    check(32'(done_cyc),    32'(s + 19), "t6_done_cycle");

    // Reset while waiting for the accumulator byte
    dn0 = done_cnt;
    pulse_go();
    wait_wr(20, "t7");
    push(8'h55);
    repeat (3) tick();
    push(8'h66);
    reset = 1'b1;
    tick();
    check(32'(busy),              32'd0, "t7_rst_busy");
    check(32'(done),              32'd0, "t7_rst_done");
    check(32'(timeout_err),       32'd0, "t7_rst_to");
    check(32'(clk_count),         32'd0, "t7_rst_clk_count");
    check(32'(acc_byte),          32'd0, "t7_rst_acc");
    check(32'(w_data),            32'd0, "t7_rst_w_data");
    check(32'(rx_tail - rx_head), 32'd1, "t7_fifo_untouched");
    reset = 1'b0;
    tick();
    check(32'(done_cnt - dn0), 32'd0, "t7_no_done_on_abort");
    rd0 = rd_cnt;
    pulse_go();
    wait_wr(20, "t7b");
    check(32'(rd_cnt - rd0), 32'd1, "t7_stale_flushed");
    push(8'h77);
    push(8'h88);
    wait_done(50, "t7b");
    check(32'(clk_count),   32'h77, "t7_clk_count");
    check(32'(acc_byte),    32'h88, "t7_acc");
    check(32'(timeout_err), 32'd0,  "t7_to");

    check(32'(bad_strb), 32'd0, "strobe_rules");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
